// File: rtl/sw_debounce_if.sv
// sw_debounce_if: switch conditioning bus.
//   Carries the raw switch pins into the debouncer and the debounced value,
//   per-bit edge pulses and the aggregate change pulse back out.
//   modport slave  : the debouncer (consumes raw pins, drives conditioned outputs)
//   modport master : the consumer side (drives raw pins, observes outputs)
//   Signals:
//     i_sw_raw     WIDTH  raw switch pins, asynchronous to i_clk, may bounce
//     o_io_sw      WIDTH  debounced switch value
//     o_sw_rise    WIDTH  one-cycle pulse per bit on a debounced 0->1 change
//     o_sw_fall    WIDTH  one-cycle pulse per bit on a debounced 1->0 change
//     o_sw_changed 1      one-cycle pulse, OR of all rise and fall bits
interface sw_debounce_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_sw_raw;
  logic [WIDTH-1:0] o_io_sw;
  logic [WIDTH-1:0] o_sw_rise;
  logic [WIDTH-1:0] o_sw_fall;
  logic             o_sw_changed;

  modport slave (
    input  i_sw_raw,
    output o_io_sw,
    output o_sw_rise,
    output o_sw_fall,
    output o_sw_changed
  );

  modport master (
    output i_sw_raw,
    input  o_io_sw,
    input  o_sw_rise,
    input  o_sw_fall,
    input  o_sw_changed
  );
endinterface

// File: rtl/sw_debounce.sv
// sw_debounce: switch input conditioning for the LSU switch read path.
//   Each raw switch bit passes through a two-flop synchroniser and an
//   independent debounce counter. A bit's debounced value flips only after
//   STABLE_CYCLES consecutive synchronised cycles that disagree with it; any
//   agreeing cycle restarts the count. Flips raise registered one-cycle
//   rise/fall pulses in the same cycle the new value appears, plus an
//   aggregate change pulse.
//   Ports:
//     i_clk    system clock
//     i_reset  asynchronous active-low reset
//     bus      sw_debounce_if.slave (i_sw_raw in; o_io_sw, o_sw_rise,
//              o_sw_fall, o_sw_changed out, all registered)
//   Parameters:
//     WIDTH          number of switch bits
//     STABLE_CYCLES  disagreeing cycles required before a flip (>= 1)
//     CNT_W          per-bit counter width, derived
module sw_debounce #(
  parameter  int WIDTH         = 32,
  parameter  int STABLE_CYCLES = 500000,
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic           i_clk,
  input  logic           i_reset,
  sw_debounce_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] deb_r;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;
  logic             changed_r;
  logic [WIDTH-1:0] flip_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             differ_s;

    assign differ_s  = sync2_r[i] ^ deb_r[i];
    // The bit flips on the edge where the disagreement run reaches STABLE_CYCLES.
    assign flip_s[i] = differ_s && (cnt_r == CNT_MAX);

    // Next count: clear on agreement or on the flip itself, else extend the run.
    always_comb begin
      cnt_nxt_s = cnt_r;
      if (!differ_s) begin
        cnt_nxt_s = '0;
      end else if (cnt_r == CNT_MAX) begin
        cnt_nxt_s = '0;
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
    end

    // Per-bit disagreement run counter.
    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_nxt_s;
      end
    end
  end

  // Synchroniser, debounced value and registered edge pulses.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_r   <= '0;
      sync2_r   <= '0;
      deb_r     <= '0;
      rise_r    <= '0;
      fall_r    <= '0;
      changed_r <= 1'b0;
    end else begin
      sync1_r   <= bus.i_sw_raw;
      sync2_r   <= sync1_r;
      // A flipping bit takes the synchronised value, which is its complement.
      deb_r     <= deb_r ^ flip_s;
      rise_r    <= flip_s & sync2_r;
      fall_r    <= flip_s & ~sync2_r;
      changed_r <= |flip_s;
    end
  end

  assign bus.o_io_sw      = deb_r;
  assign bus.o_sw_rise    = rise_r;
  assign bus.o_sw_fall    = fall_r;
  assign bus.o_sw_changed = changed_r;

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: self-checking bench for sw_debounce (WIDTH=32, STABLE_CYCLES=4).
//   Directed scenarios plus randomized switch activity, every cycle checked
//   against a behavioural model: the raw value reaches the debounce stage two
//   edges late, and a bit flips once its delayed value has differed from the
//   held value for STABLE_CYCLES consecutive edges.
module tb_sw_debounce;
  localparam int W  = 32;
  localparam int SC = 4;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b0;

  sw_debounce_if #(.WIDTH(W)) bus ();

  sw_debounce #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Model state: raw history (two-edge delay) and disagreement run per bit.
  logic [W-1:0] raw_hist [$];
  logic [W-1:0] m_deb;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;
  logic         m_chg;
  int           m_run [W];

  task automatic check_value(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_clear();
    raw_hist.delete();
    raw_hist.push_back('0);
    raw_hist.push_back('0);
    m_deb  = '0;
    m_rise = '0;
    m_fall = '0;
    m_chg  = 1'b0;
    for (int b = 0; b < W; b++) m_run[b] = 0;
  endtask

  // One clock edge of the model; raw is the value present before the edge.
  task automatic model_edge(input logic [W-1:0] raw);
    logic [W-1:0] seen;
    seen   = raw_hist.pop_front();   // value visible to the debounce stage now
    raw_hist.push_back(raw);
    m_rise = '0;
    m_fall = '0;
    for (int b = 0; b < W; b++) begin
      if (seen[b] != m_deb[b]) begin
        m_run[b] = m_run[b] + 1;
        if (m_run[b] >= SC) begin
          m_run[b] = 0;
          m_deb[b] = seen[b];
          if (seen[b]) m_rise[b] = 1'b1;
          else         m_fall[b] = 1'b1;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_chg = |(m_rise | m_fall);
  endtask

  task automatic compare_all(input string tag);
    check_value({tag, ".io_sw"},   bus.o_io_sw,   m_deb);
    check_value({tag, ".rise"},    bus.o_sw_rise, m_rise);
    check_value({tag, ".fall"},    bus.o_sw_fall, m_fall);
    check_value({tag, ".changed"}, {31'd0, bus.o_sw_changed}, {31'd0, m_chg});
  endtask

  task automatic step(input logic [W-1:0] raw, input string tag);
    bus.i_sw_raw = raw;
    @(posedge i_clk);
    model_edge(raw);
    #1;
    compare_all(tag);
  endtask

  task automatic steps(input logic [W-1:0] raw, input int n, input string tag);
    for (int k = 0; k < n; k++) step(raw, tag);
  endtask

  // Assert reset between edges and check outputs clear before the next edge.
  task automatic pulse_reset(input int hold_edges, input string tag);
    #2;
    i_reset = 1'b0;
    #1;
    check_value({tag, ".async_clr"}, bus.o_io_sw, 32'h0000_0000);
    for (int k = 0; k < hold_edges; k++) begin
      @(posedge i_clk);
      #1;
      check_value({tag, ".in_rst_io"},  bus.o_io_sw, 32'h0000_0000);
      check_value({tag, ".in_rst_chg"}, {31'd0, bus.o_sw_changed}, 32'h0000_0000);
    end
    i_reset = 1'b1;
    model_clear();
  endtask

  logic [W-1:0] raw_v;

  initial begin
    bus.i_sw_raw = 32'hFFFF_FFFF;
    model_clear();

    // Reset held with all switches high: nothing propagates.
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk);
      #1;
      check_value("rst_hold.io_sw", bus.o_io_sw, 32'h0000_0000);
    end
    i_reset = 1'b1;
    steps(32'hFFFF_FFFF, 5, "rel");
    check_value("rel.e5_io", bus.o_io_sw, 32'h0000_0000);
    step(32'hFFFF_FFFF, "rel");
    check_value("rel.e6_io",   bus.o_io_sw,   32'hFFFF_FFFF);
    check_value("rel.e6_rise", bus.o_sw_rise, 32'hFFFF_FFFF);
    check_value("rel.e6_chg",  {31'd0, bus.o_sw_changed}, 32'h0000_0001);
    step(32'hFFFF_FFFF, "rel");
    check_value("rel.e7_rise", bus.o_sw_rise, 32'h0000_0000);

    // Return to all-zero steady state, then single rise on bit 3.
    steps(32'h0000_0000, 10, "to_zero");
    steps(32'h0000_0008, 5, "rise");
    check_value("rise.e5_io", bus.o_io_sw, 32'h0000_0000);
    step(32'h0000_0008, "rise");
    check_value("rise.e6_io",   bus.o_io_sw,   32'h0000_0008);
    check_value("rise.e6_rise", bus.o_sw_rise, 32'h0000_0008);
    check_value("rise.e6_fall", bus.o_sw_fall, 32'h0000_0000);
    steps(32'h0000_0000, 10, "to_zero2");

    // Glitch on bit 0 shorter than the qualification window.
    steps(32'h0000_0001, 3, "glitch");
    steps(32'h0000_0000, 20, "glitch");
    check_value("glitch.io", bus.o_io_sw, 32'h0000_0000);

    // Bounce on bit 5, then hold high.
    step(32'h0000_0020, "bounce");
    step(32'h0000_0000, "bounce");
    step(32'h0000_0020, "bounce");
    step(32'h0000_0000, "bounce");
    steps(32'h0000_0020, 5, "bounce");
    check_value("bounce.e5_io", bus.o_io_sw, 32'h0000_0000);
    step(32'h0000_0020, "bounce");
    check_value("bounce.e6_io", bus.o_io_sw, 32'h0000_0020);
    steps(32'h0000_0020, 8, "bounce_hold");

    // Simultaneous opposite flips.
    steps(32'h0000_0002, 10, "opp_setup");
    steps(32'h0000_0001, 5, "opp");
    step(32'h0000_0001, "opp");
    check_value("opp.io",   bus.o_io_sw,   32'h0000_0001);
    check_value("opp.rise", bus.o_sw_rise, 32'h0000_0001);
    check_value("opp.fall", bus.o_sw_fall, 32'h0000_0002);
    check_value("opp.chg",  {31'd0, bus.o_sw_changed}, 32'h0000_0001);
    step(32'h0000_0001, "opp");
    check_value("opp.chg_off", {31'd0, bus.o_sw_changed}, 32'h0000_0000);

    // Reset in the middle of a qualification count.
    steps(32'h0000_0000, 10, "mid_setup");
    steps(32'h0000_0080, 4, "mid");
    pulse_reset(2, "mid");
    steps(32'h0000_0080, 5, "mid_rel");
    check_value("mid.e5_io", bus.o_io_sw, 32'h0000_0000);
    step(32'h0000_0080, "mid_rel");
    check_value("mid.e6_io",   bus.o_io_sw,   32'h0000_0080);
    check_value("mid.e6_rise", bus.o_sw_rise, 32'h0000_0080);

    // Randomized activity: mixes of short glitches and long holds.
    raw_v = 32'h0000_0080;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0) raw_v = raw_v ^ ($urandom & $urandom & $urandom);
      if (k == 750) pulse_reset(1, "rnd_rst");
      step(raw_v, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end
endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input conditioning stage directly upstream of the load/store unit's switch read path.
- Synchronises the raw board switch bus into i_clk, debounces every bit independently, and drives the stable value that the LSU returns for loads from the 0x1001_0xxx switch window.
- Also emits per-bit one-cycle rise and fall pulses and an aggregate change pulse, for future interrupt or polling use.

Parameters:
- WIDTH, 32, number of switch bits; must match the LSU switch input width.
- STABLE_CYCLES, 500000, consecutive synchronised cycles of disagreement required before a bit flips; must be >= 1 (10 ms at 50 MHz).
- CNT_W, $clog2(STABLE_CYCLES+1), width of each per-bit counter; derived, not overridden.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  reset, asynchronous, active-low
- i_sw_raw  in  WIDTH  raw switch pins; asynchronous to i_clk and may bounce
- o_io_sw  out  WIDTH  debounced switch value; connects to the LSU i_io_sw
- o_sw_rise  out  WIDTH  one-cycle pulse per bit on a debounced 0->1 change
- o_sw_fall  out  WIDTH  one-cycle pulse per bit on a debounced 1->0 change
- o_sw_changed  out  1  one-cycle pulse, equal to OR of all rise and fall bits

Behaviour:
- Reset (i_reset=0, async):
  - sync stages, counters, o_io_sw, o_sw_rise, o_sw_fall and o_sw_changed all go to 0 immediately.
  - i_sw_raw is ignored while reset is held.
- Synchroniser:
  - Two flops per bit: sync1 <= i_sw_raw, sync2 <= sync1.
  - No logic sits between the two stages.
- Per-bit counter, evaluated at each rising edge:
  - sync2 == deb: counter <= 0.
  - sync2 != deb and counter < STABLE_CYCLES-1: counter <= counter+1.
  - sync2 != deb and counter == STABLE_CYCLES-1: deb <= sync2, counter <= 0, flip event.
- Latency: if raw changes before edge k and stays stable, o_io_sw shows the new value after edge k+1+STABLE_CYCLES.
- Glitches:
  - A disagreement lasting fewer than STABLE_CYCLES sync2 cycles produces no change and no pulse.
  - Any agreeing cycle restarts the count from 0.
- STABLE_CYCLES=1: a bit flips on the first edge where sync2 disagrees, so latency is 2 edges.
- Pulses:
  - o_sw_rise[i] and o_sw_fall[i] are registered and asserted for exactly one cycle, in the same cycle the new o_io_sw[i] value first appears.
  - All three pulse outputs deassert on the next edge unless another flip occurs.
- Simultaneous events:
  - Bits are fully independent; any mix of rises and falls may pulse in the same cycle.
  - o_sw_changed is a single one-cycle pulse regardless of how many bits flip.
- Back-to-back flips of one bit are at least STABLE_CYCLES cycles apart, so rise and fall never pulse together on the same bit.
- Reset mid-count:
  - The count is discarded.
  - After release, switches held high re-qualify from 0 after 2+STABLE_CYCLES edges and produce rise pulses.
  - Switches held low produce nothing.
- Outputs are registered only; there is no combinational path from i_sw_raw to any output.
- No write path. The LSU treats o_io_sw as read-only.

Test Plan (STABLE_CYCLES=4, WIDTH=32):
- Reset and release: i_sw_raw=0xFFFF_FFFF held through reset -> o_io_sw=0 during reset. 6 edges after release o_io_sw=0xFFFF_FFFF, o_sw_rise=0xFFFF_FFFF and o_sw_changed=1 for exactly 1 cycle, then all pulses 0.
- Single rise: from all-zero steady state, i_sw_raw=0x0000_0008 -> o_io_sw=0x0000_0008 after edge 6 (not edge 5). o_sw_rise=0x8 for one cycle, o_sw_fall=0.
- Glitch rejection: bit0 high for 3 cycles, then low -> o_io_sw stays 0x0; no pulse on any output for 20 cycles.
- Bounce: bit5 toggles every cycle 5 times, then holds 1 -> o_io_sw[5]=1 exactly 6 edges after the final transition, with one rise pulse only.
- Simultaneous opposite: steady o_io_sw=0x2, raw changes to 0x1 in one cycle -> 6 edges later o_io_sw=0x1, o_sw_rise=0x1 and o_sw_fall=0x2 in the same cycle, o_sw_changed=1 for one cycle.
- Reset mid-count: raw 0->0x80, assert reset after 4 edges (count in progress), release -> o_io_sw=0 in reset, then 0x80 exactly 6 edges after release, not earlier.
